// File: rtl/tdm_stream_mux_pkg.sv
// Shared types and width helpers for the TDM stream multiplexer.
package tdm_stream_mux_pkg;

    // Widest channel index a map entry can hold; unused upper bits are constant zero.
    localparam int unsigned MaxChanW = 8;

    typedef enum logic [1:0] {SELECT, FETCH, EMIT} state_e;

    typedef struct packed {
        logic                en;
        logic [MaxChanW-1:0] chan;
    } map_entry_t;

    function automatic int unsigned slot_w(input int unsigned nr_streams);
        return (nr_streams > 1) ? int'($clog2(nr_streams)) : 1;
    endfunction

    function automatic int unsigned chan_w(input int unsigned nr_channels);
        return (nr_channels > 1) ? int'($clog2(nr_channels)) : 1;
    endfunction

endpackage

// File: rtl/tdm_stream_mux_if.sv
// Producer-side and consumer-side req/ack stream signals of the TDM multiplexer.
interface tdm_stream_mux_if #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned NR_CHANNELS = 4
) ();
    logic [NR_CHANNELS-1:0]        req_in;
    logic [NR_CHANNELS-1:0]        ack_in;
    logic [NR_CHANNELS*DWIDTH-1:0] data_in;
    logic                          req_out;
    logic                          ack_out;
    logic [DWIDTH-1:0]             data_out;

    modport master (
        output req_in,
        input  ack_in,
        input  data_in,
        output req_out,
        input  ack_out,
        output data_out
    );

    modport slave (
        input  req_in,
        output ack_in,
        output data_in,
        input  req_out,
        output ack_out,
        input  data_out
    );
endinterface

// File: rtl/tdm_slot_map.sv
// Slot-to-channel map: one write port, one combinational read port, reset-default identity map.
module tdm_slot_map import tdm_stream_mux_pkg::*; #(
    parameter int unsigned NR_STREAMS  = 16,
    parameter int unsigned NR_CHANNELS = 4,
    localparam int unsigned SW = slot_w(NR_STREAMS),
    localparam int unsigned CW = chan_w(NR_CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we_i,
    input  logic [SW-1:0] cfg_slot_i,
    input  logic [CW-1:0] cfg_chan_i,
    input  logic          cfg_en_i,
    input  logic [SW-1:0] rd_slot_i,
    output map_entry_t    rd_entry_o
);
    map_entry_t map_q [NR_STREAMS];
    map_entry_t wr_entry;

    // Channels beyond the populated range are stored as unmapped.
    always_comb begin
        wr_entry      = '0;
        wr_entry.en   = cfg_en_i && (32'(cfg_chan_i) < NR_CHANNELS);
        wr_entry.chan = MaxChanW'(cfg_chan_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < int'(NR_STREAMS); s++) begin
                if (s < int'(NR_CHANNELS)) begin
                    map_q[s] <= '{en: 1'b1, chan: MaxChanW'(s)};
                end else begin
                    map_q[s] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < int'(NR_STREAMS); s++) begin
                if (cfg_we_i && (32'(cfg_slot_i) == 32'(s))) begin
                    map_q[s] <= wr_entry;
                end
            end
        end
    end

    assign rd_entry_o = map_q[rd_slot_i];

endmodule

// File: rtl/tdm_stream_mux.sv
// Time-division stream multiplexer: fills NR_STREAMS slots per frame from mapped channels or zero.
// Optional sof output enabled by defining TDM_STREAM_MUX_SOF_EN.
module tdm_stream_mux import tdm_stream_mux_pkg::*; #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned NR_STREAMS  = 16,
    parameter int unsigned NR_CHANNELS = 4,
    localparam int unsigned SW = slot_w(NR_STREAMS),
    localparam int unsigned CW = chan_w(NR_CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    tdm_stream_mux_if.master bus,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_slot,
    input  logic [CW-1:0]    cfg_chan,
    input  logic             cfg_en,
    output logic [SW-1:0]    slot_idx
`ifdef TDM_STREAM_MUX_SOF_EN
    ,
    output logic             sof
`endif
);
    state_e                 state_q, state_d;
    logic [CW-1:0]          chan_q, chan_d;
    logic [NR_CHANNELS-1:0] req_in_q, req_in_d;
    logic                   req_out_q, req_out_d;
    logic [DWIDTH-1:0]      data_q, data_d;
    logic [SW-1:0]          slot_q, slot_d;
    map_entry_t             entry;
    logic                   acks_idle;
    logic [DWIDTH-1:0]      fetch_data;
`ifdef TDM_STREAM_MUX_SOF_EN
    logic                   sof_q, sof_d;
`endif

    tdm_slot_map #(
        .NR_STREAMS  (NR_STREAMS),
        .NR_CHANNELS (NR_CHANNELS)
    ) u_slot_map (
        .clk        (clk),
        .rst        (rst),
        .cfg_we_i   (cfg_we),
        .cfg_slot_i (cfg_slot),
        .cfg_chan_i (cfg_chan),
        .cfg_en_i   (cfg_en),
        .rd_slot_i  (slot_q),
        .rd_entry_o (entry)
    );

    // Four-phase handshake: a new slot starts only once every ack has returned to zero.
    assign acks_idle  = !bus.ack_out && (bus.ack_in == '0);
    assign fetch_data = bus.data_in[chan_q*DWIDTH +: DWIDTH];

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        req_in_d  = req_in_q;
        req_out_d = req_out_q;
        data_d    = data_q;
        slot_d    = slot_q;
`ifdef TDM_STREAM_MUX_SOF_EN
        sof_d     = sof_q;
`endif
        unique case (state_q)
            SELECT: begin
                if (acks_idle) begin
                    if (entry.en) begin
                        chan_d   = entry.chan[CW-1:0];
                        req_in_d = NR_CHANNELS'(1) << entry.chan[CW-1:0];
                        state_d  = FETCH;
                    end else begin
                        data_d    = '0;
                        req_out_d = 1'b1;
`ifdef TDM_STREAM_MUX_SOF_EN
                        sof_d     = (slot_q == '0);
`endif
                        state_d   = EMIT;
                    end
                end
            end
            FETCH: begin
                if (bus.ack_in[chan_q]) begin
                    data_d    = fetch_data;
                    req_in_d  = '0;
                    req_out_d = 1'b1;
`ifdef TDM_STREAM_MUX_SOF_EN
                    sof_d     = (slot_q == '0);
`endif
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (bus.ack_out) begin
                    req_out_d = 1'b0;
                    data_d    = '0;
`ifdef TDM_STREAM_MUX_SOF_EN
                    sof_d     = 1'b0;
`endif
                    slot_d    = (slot_q == SW'(NR_STREAMS - 1)) ? '0 : slot_q + SW'(1);
                    state_d   = SELECT;
                end
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SELECT;
            chan_q    <= '0;
            req_in_q  <= '0;
            req_out_q <= 1'b0;
            data_q    <= '0;
            slot_q    <= '0;
`ifdef TDM_STREAM_MUX_SOF_EN
            sof_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            req_in_q  <= req_in_d;
            req_out_q <= req_out_d;
            data_q    <= data_d;
            slot_q    <= slot_d;
`ifdef TDM_STREAM_MUX_SOF_EN
            sof_q     <= sof_d;
`endif
        end
    end

    assign bus.req_in   = req_in_q;
    assign bus.req_out  = req_out_q;
    assign bus.data_out = data_q;
    assign slot_idx     = slot_q;
`ifdef TDM_STREAM_MUX_SOF_EN
    assign sof          = sof_q;
`endif

endmodule

// File: tb/tb_tdm_stream_mux.sv
// Directed bench for tdm_stream_mux: default map, remapping, stalls, return-to-zero, reset.
module tb_tdm_stream_mux;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_slot;
    logic [1:0] cfg_chan;
    logic       cfg_en;
    logic [3:0] slot_idx;
`ifdef TDM_STREAM_MUX_SOF_EN
    logic       sof;
`endif

    logic       auto_in, auto_out;
    logic [3:0] man_ack_in;
    logic       man_ack_out;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int r2_cnt = 0;
    int r2_base;
    logic r2_prev = 1'b0;
    int exp_chan [16];

    tdm_stream_mux_if #(.DWIDTH(16), .NR_CHANNELS(4)) bus ();

    tdm_stream_mux #(
        .DWIDTH      (16),
        .NR_STREAMS  (16),
        .NR_CHANNELS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_slot (cfg_slot),
        .cfg_chan (cfg_chan),
        .cfg_en   (cfg_en),
        .slot_idx (slot_idx)
`ifdef TDM_STREAM_MUX_SOF_EN
        ,
        .sof      (sof)
`endif
    );

    // Peers either echo their request combinationally or take a manual ack level.
    assign bus.ack_in  = auto_in  ? bus.req_in  : man_ack_in;
    assign bus.ack_out = auto_out ? bus.req_out : man_ack_out;
    assign bus.data_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && (((bus.req_in & (bus.req_in - 4'd1)) != 4'd0) ||
                    ((bus.req_in != 4'd0) && bus.req_out))) viol++;
        if (bus.req_in[2] && !r2_prev) r2_cnt++;
        r2_prev = bus.req_in[2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input int s);
        return (exp_chan[s] < 0) ? 16'h0000 : 16'hA000 + 16'(exp_chan[s]);
    endfunction

    task automatic map_default();
        for (int s = 0; s < 16; s++) exp_chan[s] = (s < 4) ? s : -1;
    endtask

    task automatic cfg_write(input int slot, input int chan, input logic en);
        cfg_we   = 1'b1;
        cfg_slot = 4'(slot);
        cfg_chan = 2'(chan);
        cfg_en   = en;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic check_sample(input int exp_slot, input logic [15:0] exp_d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_out && n < 40);
        chk("req_out_seen", {31'b0, bus.req_out}, 32'd1);
        chk("slot_idx", {28'b0, slot_idx}, 32'(exp_slot));
        chk("data_out", {16'b0, bus.data_out}, {16'b0, exp_d});
`ifdef TDM_STREAM_MUX_SOF_EN
        chk("sof", {31'b0, sof}, (exp_slot == 0) ? 32'd1 : 32'd0);
`endif
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_in"}, {28'b0, bus.req_in}, 32'd0);
        chk({tag, "_req_out"}, {31'b0, bus.req_out}, 32'd0);
        chk({tag, "_data_out"}, {16'b0, bus.data_out}, 32'd0);
        chk({tag, "_slot_idx"}, {28'b0, slot_idx}, 32'd0);
`ifdef TDM_STREAM_MUX_SOF_EN
        chk({tag, "_sof"}, {31'b0, sof}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        rst = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_chan = '0; cfg_en = 1'b0;
        auto_in = 1'b1; auto_out = 1'b1; man_ack_in = '0; man_ack_out = 1'b0;
        map_default();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;

        // Two frames with the default map.
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 16; s++) check_sample(s, exp_data(s));

        // Stall slot 15 in EMIT while reprogramming.
        auto_out = 1'b0;
        cfg_write(0, 0, 1'b0); exp_chan[0] = -1;
        cfg_write(5, 2, 1'b1); exp_chan[5] = 2;
        cfg_write(7, 3, 1'b1); exp_chan[7] = 3;
        auto_out = 1'b1;
        r2_base = r2_cnt;

        for (int s = 0; s < 16; s++) begin
            check_sample(s, exp_data(s));
            if (s == 5) begin
                auto_out = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_req_out", {31'b0, bus.req_out}, 32'd1);
                    chk("stall_data_out", {16'b0, bus.data_out}, 32'h0000A002);
                    chk("stall_req_in", {28'b0, bus.req_in}, 32'd0);
                    chk("stall_slot_idx", {28'b0, slot_idx}, 32'd5);
                end
                auto_out = 1'b1;
            end
        end
        chk("req_in2_rises", 32'(r2_cnt - r2_base), 32'd2);

        // ack_out stuck high: no new request until it returns to zero.
        check_sample(0, exp_data(0));
        check_sample(1, exp_data(1));
        auto_out = 1'b0; man_ack_out = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rtz_req_in", {28'b0, bus.req_in}, 32'd0);
            chk("rtz_req_out", {31'b0, bus.req_out}, 32'd0);
            chk("rtz_slot_idx", {28'b0, slot_idx}, 32'd2);
        end
        auto_in = 1'b0; man_ack_in = '0; man_ack_out = 1'b0; auto_out = 1'b1;
        @(negedge clk);
        chk("fetch_req_in", {28'b0, bus.req_in}, 32'd4);

        // Remap the in-flight slot; the current sample keeps the old channel.
        cfg_write(2, 1, 1'b1);
        chk("fetch_req_in_held", {28'b0, bus.req_in}, 32'd4);
        auto_in = 1'b1;
        check_sample(2, 16'hA002);
        exp_chan[2] = 1;
        for (int s = 3; s < 16; s++) check_sample(s, exp_data(s));
        for (int s = 0; s < 7; s++) check_sample(s, exp_data(s));

        // Reset while fetching slot 7.
        auto_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_in != 4'b1000 && n < 20);
        chk("slot7_req_in", {28'b0, bus.req_in}, 32'd8);
        chk("slot7_slot_idx", {28'b0, slot_idx}, 32'd7);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");
        rst = 1'b1; auto_in = 1'b1;
        map_default();
        for (int s = 0; s < 8; s++) check_sample(s, exp_data(s));

        chk("handshake_exclusive", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
